// File: rtl/cpu_bus_arbiter.sv
// CPU memory bus arbiter: N masters, N slave decode windows, registered grant and read return.
// One dead cycle separates owners; slave-side signals follow the current owner combinationally.
module cpu_bus_arbiter #(
  parameter int unsigned          N_MST     = 2,
  parameter int unsigned          N_SLV     = 4,
  parameter int unsigned          AW        = 16,
  parameter int unsigned          DW        = 8,
  parameter int unsigned          ARB_MODE  = 0,
  parameter logic [N_SLV*AW-1:0]  SLV_BASE  = {16'h8000, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [N_SLV*AW-1:0]  SLV_MASK  = {16'h8000, 16'hFFE0, 16'hE000, 16'hE000},
  parameter logic [DW-1:0]        UNMAP_VAL = '0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [N_MST-1:0]    m_req_in,
  input  logic [N_MST-1:0]    m_lock_in,
  input  logic [N_MST-1:0]    m_r_nw_in,
  input  logic [N_MST*AW-1:0] m_a_in,
  input  logic [N_MST*DW-1:0] m_d_in,
  output logic [N_MST-1:0]    m_gnt_out,
  output logic [DW-1:0]       m_d_out,
  output logic [N_MST-1:0]    m_rvld_out,
  output logic                m_err_out,
  output logic [N_SLV-1:0]    s_sel_out,
  output logic                s_r_nw_out,
  output logic [AW-1:0]       s_a_out,
  output logic [DW-1:0]       s_d_out,
  input  logic [N_SLV*DW-1:0] s_d_in
);

  localparam int unsigned OW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   rr_ptr, rr_ptr_nxt, rr_idx;
  logic [OW-1:0]   win;
  logic            win_vld;
  logic [N_MST-1:0] owner_oh, others, gnt_nxt;
  logic            access, hit;
  logic [SW-1:0]   hit_idx;
  logic [AW-1:0]   own_a;
  logic [DW-1:0]   own_d;
  logic            own_r_nw;

  // rr_ptr holds the first index to consider, i.e. one past the last owner
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    rr_idx  = '0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < N_MST; i++) begin
        if (m_req_in[i]) begin
          win     = OW'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N_MST; k++) begin
        rr_idx = OW'((32'(rr_ptr) + k) % N_MST);
        if (!win_vld && m_req_in[rr_idx]) begin
          win     = rr_idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    others          = m_req_in & ~owner_oh;
    state_nxt       = state;
    owner_nxt       = owner;
    rr_ptr_nxt      = rr_ptr;
    gnt_nxt         = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt  = GRANT;
          owner_nxt  = win;
          rr_ptr_nxt = (32'(win) == N_MST - 1) ? '0 : win + 1'b1;
        end
      end
      GRANT: begin
        if (!m_req_in[owner] || (!m_lock_in[owner] && |others))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GRANT)
      gnt_nxt[owner_nxt] = 1'b1;
  end

  always_comb begin
    access   = (state == GRANT) && m_req_in[owner] && !rst_in;
    own_a    = m_a_in[owner*AW +: AW];
    own_d    = m_d_in[owner*DW +: DW];
    own_r_nw = m_r_nw_in[owner];
    hit      = 1'b0;
    hit_idx  = '0;
    for (int unsigned s = 0; s < N_SLV; s++) begin
      if (!hit && ((own_a & SLV_MASK[s*AW +: AW]) == (SLV_BASE[s*AW +: AW] & SLV_MASK[s*AW +: AW]))) begin
        hit     = 1'b1;
        hit_idx = SW'(s);
      end
    end
    s_sel_out = '0;
    if (access && hit)
      s_sel_out[hit_idx] = 1'b1;
    s_r_nw_out = access ? own_r_nw : 1'b1;
    s_a_out    = access ? own_a : '0;
    s_d_out    = access ? own_d : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      m_gnt_out  <= '0;
      m_rvld_out <= '0;
      m_err_out  <= 1'b0;
      m_d_out    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_ptr_nxt;
      m_gnt_out  <= gnt_nxt;
      m_err_out  <= access && !hit;
      m_rvld_out <= '0;
      if (access && own_r_nw) begin
        m_rvld_out <= owner_oh;
        m_d_out    <= hit ? s_d_in[hit_idx*DW +: DW] : UNMAP_VAL;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: a fixed-priority and a round-robin instance share stimulus;
// directed vector table first, then random traffic against an ownership-level reference model.
module tb_cpu_bus_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;
  localparam logic [NS*16-1:0] BASE  = {16'hC000, 16'h8000, 16'h2000, 16'h0000};
  localparam logic [NS*16-1:0] MASK  = {16'hC000, 16'h8000, 16'hE000, 16'hE000};
  localparam logic [7:0]       UNMAP = 8'hEE;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock, rnw;
  logic [31:0] m_a;
  logic [15:0] m_d;
  logic [31:0] s_d;

  logic [1:0]  gnt_f, rvld_f, gnt_r, rvld_r;
  logic [7:0]  dout_f, dout_r, sd_f, sd_r;
  logic        err_f, err_r, snw_f, snw_r;
  logic [3:0]  sel_f, sel_r;
  logic [15:0] sa_f, sa_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.N_MST(2), .N_SLV(4), .AW(16), .DW(8), .ARB_MODE(0),
                    .SLV_BASE(BASE), .SLV_MASK(MASK), .UNMAP_VAL(UNMAP)) u_fix (
    .clk_in(clk), .rst_in(rst), .m_req_in(req), .m_lock_in(lock), .m_r_nw_in(rnw),
    .m_a_in(m_a), .m_d_in(m_d), .m_gnt_out(gnt_f), .m_d_out(dout_f), .m_rvld_out(rvld_f),
    .m_err_out(err_f), .s_sel_out(sel_f), .s_r_nw_out(snw_f), .s_a_out(sa_f),
    .s_d_out(sd_f), .s_d_in(s_d));

  cpu_bus_arbiter #(.N_MST(2), .N_SLV(4), .AW(16), .DW(8), .ARB_MODE(1),
                    .SLV_BASE(BASE), .SLV_MASK(MASK), .UNMAP_VAL(UNMAP)) u_rr (
    .clk_in(clk), .rst_in(rst), .m_req_in(req), .m_lock_in(lock), .m_r_nw_in(rnw),
    .m_a_in(m_a), .m_d_in(m_d), .m_gnt_out(gnt_r), .m_d_out(dout_r), .m_rvld_out(rvld_r),
    .m_err_out(err_r), .s_sel_out(sel_r), .s_r_nw_out(snw_r), .s_a_out(sa_r),
    .s_d_out(sd_r), .s_d_in(s_d));

  // owner = -1 means nobody holds the bus; start = first master considered by round-robin
  typedef struct {
    int         owner;
    int         start;
    logic [1:0] gnt;
    logic [1:0] rvld;
    logic       err;
    logic [7:0] dout;
  } mdl_t;

  mdl_t mf, mr;

  typedef struct {
    logic       rst;
    logic [1:0] req, lock, rnw;
    logic [15:0] a0, a1;
    logic [1:0] gf, vf;
    logic       ef;
    logic [7:0] df;
    logic [1:0] gr, vr;
    logic       er;
    logic [7:0] dr;
  } vec_t;

  function automatic logic bit_of(logic [1:0] v, int i);
    return ((v >> i) & 2'b01) != 2'b00;
  endfunction

  function automatic int decode(logic [15:0] a);
    for (int s = 0; s < NS; s++) begin
      logic [15:0] b, m;
      b = 16'(BASE >> (16 * s));
      m = 16'(MASK >> (16 * s));
      if ((a & m) == (b & m)) return s;
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t st, bit rr);
    mdl_t n;
    n = st;
    if (rst) begin
      n.owner = -1; n.start = 0; n.gnt = '0; n.rvld = '0; n.err = 1'b0; n.dout = '0;
      return n;
    end
    n.rvld = '0;
    n.err  = 1'b0;
    if (st.owner >= 0 && bit_of(req, st.owner)) begin
      logic [15:0] a;
      int h;
      a = 16'(m_a >> (16 * st.owner));
      h = decode(a);
      n.err = (h < 0);
      if (bit_of(rnw, st.owner)) begin
        n.rvld = 2'(1 << st.owner);
        n.dout = (h < 0) ? UNMAP : 8'(s_d >> (8 * h));
      end
    end
    if (st.owner < 0) begin
      if (req != 2'b00) begin
        int w;
        w = -1;
        for (int k = 0; k < NM; k++) begin
          int i;
          i = rr ? (st.start + k) % NM : k;
          if (bit_of(req, i) && (!rr || w < 0)) w = i;
        end
        n.owner = w;
        n.start = (w + 1) % NM;
      end
    end else begin
      logic [1:0] rivals;
      rivals = req & ~2'(1 << st.owner);
      if (!bit_of(req, st.owner) || (!bit_of(lock, st.owner) && rivals != 2'b00))
        n.owner = -1;
    end
    n.gnt = (n.owner >= 0) ? 2'(1 << n.owner) : 2'b00;
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_comb(string tag, mdl_t st, logic [3:0] sel, logic nw,
                            logic [15:0] a, logic [7:0] d);
    logic acc, enw;
    logic [3:0] es;
    logic [15:0] ea;
    logic [7:0] ed;
    int h;
    acc = !rst && st.owner >= 0 && bit_of(req, st.owner);
    es = '0; enw = 1'b1; ea = '0; ed = '0;
    if (acc) begin
      ea  = 16'(m_a >> (16 * st.owner));
      ed  = 8'(m_d >> (8 * st.owner));
      enw = bit_of(rnw, st.owner);
      h   = decode(ea);
      if (h >= 0) es = 4'(1 << h);
    end
    chk({tag, "_sel"}, 32'(sel), 32'(es));
    chk({tag, "_s_r_nw"}, 32'(nw), 32'(enw));
    chk({tag, "_s_a"}, 32'(a), 32'(ea));
    chk({tag, "_s_d"}, 32'(d), 32'(ed));
  endtask

  task automatic check_regs(string tag, mdl_t st, logic [1:0] g, logic [1:0] v,
                            logic e, logic [7:0] d);
    chk({tag, "_gnt"}, 32'(g), 32'(st.gnt));
    chk({tag, "_rvld"}, 32'(v), 32'(st.rvld));
    chk({tag, "_err"}, 32'(e), 32'(st.err));
    chk({tag, "_dout"}, 32'(d), 32'(st.dout));
  endtask

  // inputs are applied 1 time unit after a rising edge; everything is sampled mid-cycle
  task automatic cycle();
    #1;
    check_comb("fix", mf, sel_f, snw_f, sa_f, sd_f);
    check_comb("rr", mr, sel_r, snw_r, sa_r, sd_r);
    mf = step(mf, 1'b0);
    mr = step(mr, 1'b1);
    @(posedge clk);
    #1;
    check_regs("fix", mf, gnt_f, rvld_f, err_f, dout_f);
    check_regs("rr", mr, gnt_r, rvld_r, err_r, dout_r);
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 16'h0005;
      1: return 16'h2001;
      2: return 16'h4020;
      3: return 16'h8000;
      4: return 16'hC000;
      default: return 16'($urandom);
    endcase
  endfunction

  vec_t vecs[21];

  initial begin
    //          rst   req    lock   rnw    a0        a1        gf     vf     ef    df      gr     vr     er    dr
    vecs = '{
      '{1'b1, 2'b11, 2'b00, 2'b11, 16'h0005, 16'h0005, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h0005, 16'h0005, 2'b10, 2'b00, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h0005, 16'h0005, 2'b00, 2'b10, 1'b0, 8'hA5, 2'b00, 2'b01, 1'b0, 8'hA5},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h0005, 16'h0005, 2'b10, 2'b00, 1'b0, 8'hA5, 2'b10, 2'b00, 1'b0, 8'hA5},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h0005, 16'h0005, 2'b00, 2'b10, 1'b0, 8'hA5, 2'b00, 2'b10, 1'b0, 8'hA5},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h0005, 16'h0005, 2'b10, 2'b00, 1'b0, 8'hA5, 2'b01, 2'b00, 1'b0, 8'hA5},
      '{1'b1, 2'b00, 2'b00, 2'b00, 16'h0005, 16'h0005, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b01, 2'b01, 2'b01, 16'h2001, 16'h0005, 2'b01, 2'b00, 1'b0, 8'h00, 2'b01, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b11, 2'b01, 2'b11, 16'h2001, 16'h0005, 2'b01, 2'b01, 1'b0, 8'hB1, 2'b01, 2'b01, 1'b0, 8'hB1},
      '{1'b0, 2'b11, 2'b01, 2'b11, 16'h2001, 16'h0005, 2'b01, 2'b01, 1'b0, 8'hB1, 2'b01, 2'b01, 1'b0, 8'hB1},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h2001, 16'h0005, 2'b00, 2'b01, 1'b0, 8'hB1, 2'b00, 2'b01, 1'b0, 8'hB1},
      '{1'b0, 2'b11, 2'b00, 2'b11, 16'h2001, 16'h0005, 2'b10, 2'b00, 1'b0, 8'hB1, 2'b10, 2'b00, 1'b0, 8'hB1},
      '{1'b0, 2'b10, 2'b00, 2'b10, 16'h0005, 16'h4020, 2'b10, 2'b10, 1'b1, 8'hEE, 2'b10, 2'b10, 1'b1, 8'hEE},
      '{1'b0, 2'b10, 2'b00, 2'b00, 16'h0005, 16'h4000, 2'b10, 2'b00, 1'b1, 8'hEE, 2'b10, 2'b00, 1'b1, 8'hEE},
      '{1'b0, 2'b10, 2'b00, 2'b00, 16'h0005, 16'h8000, 2'b10, 2'b00, 1'b0, 8'hEE, 2'b10, 2'b00, 1'b0, 8'hEE},
      '{1'b0, 2'b10, 2'b00, 2'b10, 16'h0005, 16'hC000, 2'b10, 2'b10, 1'b0, 8'hC2, 2'b10, 2'b10, 1'b0, 8'hC2},
      '{1'b1, 2'b10, 2'b00, 2'b10, 16'h0005, 16'h0005, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b00, 2'b00, 2'b00, 16'h0005, 16'h0005, 2'b00, 2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b10, 2'b00, 2'b10, 16'h0005, 16'h0005, 2'b10, 2'b00, 1'b0, 8'h00, 2'b10, 2'b00, 1'b0, 8'h00},
      '{1'b0, 2'b10, 2'b00, 2'b10, 16'h0005, 16'h0005, 2'b10, 2'b10, 1'b0, 8'hA5, 2'b10, 2'b10, 1'b0, 8'hA5},
      '{1'b0, 2'b00, 2'b00, 2'b00, 16'h0005, 16'h0005, 2'b00, 2'b00, 1'b0, 8'hA5, 2'b00, 2'b00, 1'b0, 8'hA5}
    };

    rst  = 1'b1; req = '0; lock = '0; rnw = '0;
    m_a  = '0;
    m_d  = {8'h22, 8'h11};
    s_d  = {8'hD3, 8'hC2, 8'hB1, 8'hA5};
    mf   = '{owner: -1, start: 0, gnt: '0, rvld: '0, err: 1'b0, dout: '0};
    mr   = mf;

    for (int i = 0; i < 21; i++) begin
      rst  = vecs[i].rst;
      req  = vecs[i].req;
      lock = vecs[i].lock;
      rnw  = vecs[i].rnw;
      m_a  = {vecs[i].a1, vecs[i].a0};
      cycle();
      chk($sformatf("vec%0d_gnt_fix", i), 32'(gnt_f), 32'(vecs[i].gf));
      chk($sformatf("vec%0d_rvld_fix", i), 32'(rvld_f), 32'(vecs[i].vf));
      chk($sformatf("vec%0d_err_fix", i), 32'(err_f), 32'(vecs[i].ef));
      chk($sformatf("vec%0d_dout_fix", i), 32'(dout_f), 32'(vecs[i].df));
      chk($sformatf("vec%0d_gnt_rr", i), 32'(gnt_r), 32'(vecs[i].gr));
      chk($sformatf("vec%0d_rvld_rr", i), 32'(rvld_r), 32'(vecs[i].vr));
      chk($sformatf("vec%0d_err_rr", i), 32'(err_r), 32'(vecs[i].er));
      chk($sformatf("vec%0d_dout_rr", i), 32'(dout_r), 32'(vecs[i].dr));
    end

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom);
      lock = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      rnw  = 2'($urandom);
      m_a  = {pick_addr(), pick_addr()};
      m_d  = 16'($urandom);
      s_d  = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
